sdram_host_arbiter: RTL and testbench
=====================================

# sdram_host_arbiter

Two-port round-robin arbiter and transaction sequencer for the SDRAM controller's single-word host interface (`haddr`, `data_input`, `data_output`, `busy`, `rd_enable`, `wr_enable`). Lets two requesters (e.g. CPU bus bridge and a DMA/video fetcher) share one controller with a req/ack handshake. It hides the controller's "pulse enable, wait on busy" protocol, returns read data with a single-cycle ack, and flags a controller that never accepts a command.

## Interface
Parameters:
- `HADDR_WIDTH`, 24: host word address width; matches the controller's `ROW_WIDTH + COL_WIDTH + BANK_WIDTH`.
- `DATA_WIDTH`, 16: data word width.
- `ACCEPT_TIMEOUT`, 15: maximum cycles to wait for `busy` to rise after issue. Range 1..255.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `p0_req` / `p1_req`  in  1  request level; held until ack.
- `p0_we` / `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr` / `p1_addr`  in  HADDR_WIDTH  word address.
- `p0_wdata` / `p1_wdata`  in  DATA_WIDTH  write data.
- `p0_ack` / `p1_ack`  out  1  one-cycle completion pulse.
- `p0_err` / `p1_err`  out  1  valid with ack; 1 = accept timeout.
- `p0_rdata` / `p1_rdata`  out  DATA_WIDTH  read data; valid with ack, held until that port's next ack.
- `haddr`  out  HADDR_WIDTH  controller address.
- `data_input`  out  DATA_WIDTH  controller write data.
- `rd_enable` / `wr_enable`  out  1  controller command strobes.
- `busy`  in  1  controller busy.
- `data_output`  in  DATA_WIDTH  controller read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, RESP.
- IDLE:
  - Grant a request only when `busy`=0.
  - Single request: that port wins.
  - Both requesting: the port not granted last wins. `last_grant` resets to 1, so p0 wins the first tie.
  - On grant: latch port id, `we`, `addr`, `wdata`; update `last_grant`; go to ISSUE.
- ISSUE:
  - Drive latched `haddr`/`data_input`.
  - Assert exactly one of `rd_enable`/`wr_enable` for exactly one cycle.
  - Go to WAIT_ACCEPT and clear the timeout counter.
- WAIT_ACCEPT:
  - `busy`=1: go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches ACCEPT_TIMEOUT, set the error flag and go to RESP.
- WAIT_DONE: on the first cycle `busy`=0, register `data_output` into the granted port's rdata (reads only; writes leave rdata unchanged), then go to RESP.
- RESP: pulse the granted port's ack for one cycle (err as flagged), then return to IDLE.
- Only one transaction is outstanding at a time. No pipelining, no bursts.
- Request inputs are sampled only at grant. Deasserting req or changing addr/wdata mid-transaction does not abort it, and ack still pulses.
- A port whose req is still high in the cycle after its ack is treated as a new request.
- `rst` at any state:
  - Next cycle: state IDLE, all outputs 0, `last_grant`=1, error flag 0.
  - An in-flight transaction is dropped with no ack.
  - The controller may still be busy; IDLE waits for `busy`=0 before the next grant.

## Timing
- Reset values: `p*_ack`, `p*_err`, `p*_rdata`, `haddr`, `data_input`, `rd_enable`, `wr_enable` all 0.
- All outputs are registered.
- Cycle numbering, starting from the edge where a request is granted in IDLE:
  - Edge T: grant.
  - Cycle T+1: strobe high.
  - Cycle T+2: first `busy` sample.
- `busy` seen high at sample k, then seen low at sample m: data is captured on edge m, and ack is high in the following cycle.
- Minimum grant-to-ack latency is 4 cycles, with `busy` high for exactly one sample.
- Timeout ack comes ACCEPT_TIMEOUT+2 cycles after the strobe.
- Arbiter gap: IDLE lasts at least one cycle between transactions. Under continuous contention, grants strictly alternate p0, p1, p0, …
- `haddr`/`data_input` hold the latched values from ISSUE through RESP.

## Structure
- Shared package `sdram_arb_pkg`:
  - State encoding localparams: IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, RESP.
  - Default widths HADDR_WIDTH=24 and DATA_WIDTH=16, kept consistent with the controller.
- One sub-module, `sdram_rr_pick`:
  - Combinational 2-way round-robin pick.
  - Inputs: `req[1:0]`, `last_grant`. Outputs: `gnt_valid`, `gnt_id`.
  - Unit-testable on its own.
- FSM, timeout counter and data registers live in the top module.

## Test plan
- Single write: p0 write addr 0x000123, data 0xBEEF; `busy` high for 3 cycles. Expect `wr_enable` one cycle with `haddr`=0x000123 and `data_input`=0xBEEF, then `p0_ack`=1 and `p0_err`=0 exactly once; p1 outputs stay 0.
- Single read: p1 read addr 0x7FFFFF; model returns 0x1234 when `busy` falls. Expect `p1_rdata`=0x1234 with `p1_ack`, and `rd_enable` pulsed exactly once.
- Contention: both ports hold req continuously for 6 transactions. Expect grant order p0, p1, p0, p1, p0, p1 and no back-to-back grant to the same port.
- Timeout: ACCEPT_TIMEOUT=15 and `busy` never rises. Expect `p0_ack`=1 with `p0_err`=1 exactly 17 cycles after the strobe, and the FSM back in IDLE.
- Reset mid-op: assert `rst` during WAIT_DONE. Expect all outputs 0 the next cycle and no ack. After release, while `busy` is still high, no grant; the grant follows `busy`=0, and p0 wins the first tie.
- Busy at idle: req arrives while `busy`=1 from a prior op. Expect no strobe until the cycle after `busy` is sampled 0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM host-port arbiter.
package sdram_arb_pkg;

   localparam int unsigned HADDR_WIDTH_DEF = 24;
   localparam int unsigned DATA_WIDTH_DEF  = 16;
   localparam int unsigned CNT_W           = 8;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      ISSUE       = 3'd1,
      WAIT_ACCEPT = 3'd2,
      WAIT_DONE   = 3'd3,
      RESP        = 3'd4
   } arb_state_e;

   // Latched identity of the transaction in flight.
   typedef struct packed {
      logic id;
      logic we;
   } txn_meta_t;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational two-way round-robin pick: on a tie the port not granted last wins.
module sdram_rr_pick (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt_valid,
   output logic       gnt_id
);

   always_comb begin
      gnt_valid = |req;
      gnt_id    = 1'b0;
      if (req == 2'b11) begin
         gnt_id = ~last_grant;
      end else begin
         gnt_id = req[1];
      end
   end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Two-port arbiter and single-word sequencer in front of the SDRAM controller host interface.
module sdram_host_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned HADDR_WIDTH    = HADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int unsigned ACCEPT_TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   p0_req,
   input  logic                   p0_we,
   input  logic [HADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0]  p0_wdata,
   output logic                   p0_ack,
   output logic                   p0_err,
   output logic [DATA_WIDTH-1:0]  p0_rdata,
   input  logic                   p1_req,
   input  logic                   p1_we,
   input  logic [HADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0]  p1_wdata,
   output logic                   p1_ack,
   output logic                   p1_err,
   output logic [DATA_WIDTH-1:0]  p1_rdata,
   output logic [HADDR_WIDTH-1:0] haddr,
   output logic [DATA_WIDTH-1:0]  data_input,
   output logic                   rd_enable,
   output logic                   wr_enable,
   input  logic                   busy,
   input  logic [DATA_WIDTH-1:0]  data_output
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(ACCEPT_TIMEOUT);

   arb_state_e             state_q, state_d;
   txn_meta_t              meta_q, meta_d;
   logic                   last_grant_q, last_grant_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [HADDR_WIDTH-1:0] haddr_q, haddr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic                   rd_en_q, rd_en_d, wr_en_q, wr_en_d;
   logic [1:0]             ack_q, ack_d, err_q, err_d;
   logic [DATA_WIDTH-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic                   gnt_valid, gnt_id;

   sdram_rr_pick u_pick (
      .req        ({p1_req, p0_req}),
      .last_grant (last_grant_q),
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         meta_q       <= '0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         haddr_q      <= '0;
         wdata_q      <= '0;
         rd_en_q      <= 1'b0;
         wr_en_q      <= 1'b0;
         ack_q        <= '0;
         err_q        <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         meta_q       <= meta_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         haddr_q      <= haddr_d;
         wdata_q      <= wdata_d;
         rd_en_q      <= rd_en_d;
         wr_en_q      <= wr_en_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   // Strobes, ack and err are single-cycle: they default low and are only set on the entering transition.
   always_comb begin
      state_d      = state_q;
      meta_d       = meta_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      haddr_d      = haddr_q;
      wdata_d      = wdata_q;
      rd_en_d      = 1'b0;
      wr_en_d      = 1'b0;
      ack_d        = '0;
      err_d        = '0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      unique case (state_q)
         IDLE: begin
            if (!busy && gnt_valid) begin
               meta_d.id    = gnt_id;
               meta_d.we    = gnt_id ? p1_we : p0_we;
               haddr_d      = gnt_id ? p1_addr : p0_addr;
               wdata_d      = gnt_id ? p1_wdata : p0_wdata;
               last_grant_d = gnt_id;
               rd_en_d      = ~meta_d.we;
               wr_en_d      = meta_d.we;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT_ACCEPT;
         end
         WAIT_ACCEPT: begin
            if (busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == TIMEOUT_C) begin
               ack_d[meta_q.id] = 1'b1;
               err_d[meta_q.id] = 1'b1;
               state_d          = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!busy) begin
               if (!meta_q.we) begin
                  if (meta_q.id) rdata1_d = data_output;
                  else           rdata0_d = data_output;
               end
               ack_d[meta_q.id] = 1'b1;
               state_d          = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign haddr      = haddr_q;
   assign data_input = wdata_q;
   assign rd_enable  = rd_en_q;
   assign wr_enable  = wr_en_q;
   assign p0_ack     = ack_q[0];
   assign p1_ack     = ack_q[1];
   assign p0_err     = err_q[0];
   assign p1_err     = err_q[1];
   assign p0_rdata   = rdata0_q;
   assign p1_rdata   = rdata1_q;

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Scoreboard bench for sdram_host_arbiter with a behavioural controller busy/data model.
module tb_sdram_host_arbiter;

   localparam int unsigned AW = 24;
   localparam int unsigned DW = 16;
   localparam int unsigned TO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          p0_req, p0_we, p1_req, p1_we;
   logic [AW-1:0] p0_addr, p1_addr, haddr;
   logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, data_input, data_output;
   logic          p0_ack, p0_err, p1_ack, p1_err, rd_enable, wr_enable, busy;

   typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } cmd_t;
   typedef struct packed { logic port; logic err; logic [DW-1:0] rdata; } rsp_t;

   cmd_t          cmd_q[$];
   rsp_t          rsp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            strobe_cnt = 0;
   logic [DW-1:0] exp_rd [2];

   // controller model knobs
   int            mdl_len = 1;
   int            rem = 0;
   logic [DW-1:0] mdl_val = '0;
   logic          mdl_busy, ext_busy, pend, busy_at_edge;

   sdram_host_arbiter #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCEPT_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .haddr(haddr), .data_input(data_input), .rd_enable(rd_enable), .wr_enable(wr_enable),
      .busy(busy), .data_output(data_output)
   );

   always #5 clk = ~clk;
   assign busy = mdl_busy | ext_busy;
   always @(posedge clk) busy_at_edge <= busy;

   // Controller: busy rises the cycle after a strobe and stays high mdl_len cycles; 0 = never accepts.
   initial begin
      mdl_busy = 1'b0; pend = 1'b0; data_output = '0;
      forever begin
         @(negedge clk);
         if (mdl_busy) begin
            rem = rem - 1;
            if (rem == 0) begin
               mdl_busy    = 1'b0;
               data_output = mdl_val;
            end
         end else if (pend) begin
            pend = 1'b0;
            if (mdl_len > 0) begin
               mdl_busy = 1'b1;
               rem      = mdl_len;
            end
         end
         if (rd_enable | wr_enable) pend = 1'b1;
      end
   end

   // Monitor: pops expected commands on each strobe and expected responses on each ack.
   initial begin
      logic          prev_strobe;
      logic [AW-1:0] last_addr;
      cmd_t          c;
      rsp_t          r;
      logic [DW-1:0] act_rd;
      prev_strobe = 1'b0;
      last_addr   = '0;
      forever begin
         @(negedge clk);
         if (rd_enable | wr_enable) begin
            strobe_cnt++;
            checks++;
            if (prev_strobe || (rd_enable && wr_enable)) begin
               errors++;
               $display("FAIL strobe_shape: rd=%0b wr=%0b prev=%0b, required one strobe for one cycle",
                        rd_enable, wr_enable, prev_strobe);
            end
            checks++;
            if (busy_at_edge) begin
               errors++;
               $display("FAIL grant_while_busy: busy sampled %0b at grant edge, required 0", busy_at_edge);
            end
            checks++;
            if (cmd_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe: haddr=%h wr=%0b", haddr, wr_enable);
            end else begin
               c = cmd_q.pop_front();
               if (wr_enable != c.we || haddr != c.addr || data_input != c.wdata) begin
                  errors++;
                  $display("FAIL cmd: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                           wr_enable, haddr, data_input, c.we, c.addr, c.wdata);
               end
            end
            last_addr = haddr;
         end
         if (p0_ack | p1_ack) begin
            checks++;
            if (rsp_q.size() == 0 || (p0_ack && p1_ack)) begin
               errors++;
               $display("FAIL unexpected_ack: p0_ack=%0b p1_ack=%0b queued=%0d", p0_ack, p1_ack, rsp_q.size());
            end else begin
               r      = rsp_q.pop_front();
               act_rd = p1_ack ? p1_rdata : p0_rdata;
               if (p1_ack != r.port || (p1_ack ? p1_err : p0_err) != r.err || act_rd != r.rdata) begin
                  errors++;
                  $display("FAIL rsp: got port=%0d err=%0b rdata=%h, required port=%0d err=%0b rdata=%h",
                           p1_ack, p1_ack ? p1_err : p0_err, act_rd, r.port, r.err, r.rdata);
               end
            end
            checks++;
            if (haddr != last_addr) begin
               errors++;
               $display("FAIL haddr_hold: got %h at ack, required %h", haddr, last_addr);
            end
         end
         if ((p0_err && !p0_ack) || (p1_err && !p1_ack)) begin
            checks++;
            errors++;
            $display("FAIL err_without_ack: p0_err=%0b p1_err=%0b", p0_err, p1_err);
         end
         prev_strobe = rd_enable | wr_enable;
      end
   end

   task automatic wait_strobe(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = rd_enable | wr_enable;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL strobe_timeout: no strobe within 100 cycles, required one");
      end
   endtask

   task automatic wait_ack(input logic port, output int cyc);
      logic seen;
      seen = 1'b0;
      cyc  = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         cyc++;
         seen = port ? p1_ack : p0_ack;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL ack_timeout: port %0d no ack within 200 cycles", port);
      end
   endtask

   task automatic drive(input logic port, input logic req, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      if (port) begin p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
      else      begin p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
   endtask

   task automatic expect_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic err, input logic [DW-1:0] val);
      cmd_t c;
      rsp_t r;
      c = '{we: we, addr: addr, wdata: wdata};
      cmd_q.push_back(c);
      if (!we && !err) exp_rd[port] = val;
      r = '{port: port, err: err, rdata: exp_rd[port]};
      rsp_q.push_back(r);
   endtask

   // One isolated transaction; len = busy cycles (0 = timeout), pre = cycles of foreign busy before the request.
   task automatic do_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int len, input logic [DW-1:0] val, input int pre);
      logic ok;
      int   cyc, exp_cyc, s0;
      mdl_len = len;
      mdl_val = val;
      expect_txn(port, we, addr, wdata, len == 0, val);
      exp_cyc = (len == 0) ? int'(TO) + 2 : len + 2;
      s0 = strobe_cnt;
      if (pre > 0) ext_busy = 1'b1;
      drive(port, 1'b1, we, addr, wdata);
      if (pre > 0) begin
         repeat (pre) @(negedge clk);
         checks++;
         if (strobe_cnt != s0) begin
            errors++;
            $display("FAIL busy_idle: %0d strobes while busy high, required 0", strobe_cnt - s0);
         end
         ext_busy = 1'b0;
      end
      wait_strobe(ok);
      if (ok) begin
         wait_ack(port, cyc);
         checks++;
         if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL latency: strobe-to-ack %0d cycles, required %0d", cyc, exp_cyc);
         end
      end
      drive(port, 1'b0, we, addr, wdata);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_zero(input string name);
      logic [4*DW+AW+6-1:0] v;
      v = {p0_ack, p1_ack, p0_err, p1_err, rd_enable, wr_enable, p0_rdata, p1_rdata, haddr, data_input};
      checks++;
      if (v != '0) begin
         errors++;
         $display("FAIL %s: outputs %h, required all zero", name, v);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      int   cyc, n;
      rst = 1'b1; ext_busy = 1'b0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst = 1'b0;
      @(negedge clk);

      do_txn(1'b0, 1'b1, 24'h000123, 16'hBEEF, 3, 16'h0000, 0);
      do_txn(1'b1, 1'b0, 24'h7FFFFF, 16'h0000, 2, 16'h1234, 0);
      do_txn(1'b0, 1'b0, 24'h000456, 16'h0000, 1, 16'hA5A5, 0);
      do_txn(1'b0, 1'b0, 24'h000789, 16'h0000, 0, 16'hDEAD, 0);
      do_txn(1'b1, 1'b1, 24'h000ABC, 16'h5555, 2, 16'h0000, 0);

      // Contention: last grant was p1, so p0 takes the first tie.
      mdl_len = 1;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) expect_txn(1'b0, 1'b1, 24'h0000A0, 16'h00A0, 1'b0, 16'h0000);
         else            expect_txn(1'b1, 1'b1, 24'h0000B1, 16'h00B1, 1'b0, 16'h0000);
      end
      drive(1'b0, 1'b1, 1'b1, 24'h0000A0, 16'h00A0);
      drive(1'b1, 1'b1, 1'b1, 24'h0000B1, 16'h00B1);
      n = 0;
      for (int i = 0; i < 400 && n < 6; i++) begin
         @(negedge clk);
         if (p0_ack | p1_ack) n++;
      end
      drive(1'b0, 1'b0, 1'b1, 24'h0000A0, 16'h00A0);
      drive(1'b1, 1'b0, 1'b1, 24'h0000B1, 16'h00B1);
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL contention_count: %0d acks, required 6", n);
      end
      repeat (2) @(negedge clk);

      // Reset in WAIT_DONE of a p0 read: last grant would be p0, reset restores p1 so p0 still wins.
      mdl_len = 5;
      expect_txn(1'b0, 1'b0, 24'h000222, 16'h0000, 1'b0, 16'h0000);
      void'(rsp_q.pop_back());
      drive(1'b0, 1'b1, 1'b0, 24'h000222, 16'h0000);
      wait_strobe(ok);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 24'h000333, 16'h3333);
      drive(1'b1, 1'b1, 1'b0, 24'h000444, 16'h0000);
      @(negedge clk);
      check_zero("reset_midop");
      rst = 1'b0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      mdl_len = 1;
      mdl_val = 16'h2468;
      expect_txn(1'b0, 1'b1, 24'h000333, 16'h3333, 1'b0, 16'h0000);
      expect_txn(1'b1, 1'b0, 24'h000444, 16'h0000, 1'b0, 16'h2468);
      wait_ack(1'b0, cyc);
      drive(1'b0, 1'b0, 1'b1, 24'h000333, 16'h3333);
      wait_ack(1'b1, cyc);
      drive(1'b1, 1'b0, 1'b0, 24'h000444, 16'h0000);
      repeat (2) @(negedge clk);

      do_txn(1'b1, 1'b0, 24'h000999, 16'h0000, 1, 16'h0F0F, 4);

      repeat (5) @(negedge clk);
      checks++;
      if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d commands and %0d responses never seen, required 0",
                  cmd_q.size(), rsp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
